// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute/write-back stage.
package alu_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 4;
  localparam int MUL_ITER   = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_LDI = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_ALU  = 2'd1,
    EX_MUL  = 2'd2
  } ex_state_e;

  function automatic logic is_mul(input alu_op_e op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// i_start is pulsed in the first iteration with the operands; o_done marks the
// last iteration (count MUL_ITER-1), when o_result carries the low DW bits.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic          o_done,
  output logic [DW-1:0] o_result
);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [DW-1:0]    r_acc;

  logic             w_active;
  logic [CNT_W-1:0] w_cnt;
  logic [DW-1:0]    w_a;
  logic [DW-1:0]    w_b;
  logic [DW-1:0]    w_acc;
  logic [DW-1:0]    w_sum;

  // Current iteration: the start cycle uses the fresh operands directly.
  always_comb begin
    w_active = i_start | r_busy;
    w_cnt    = i_start ? '0 : r_cnt;
    w_a      = i_start ? i_a : r_a;
    w_b      = i_start ? i_b : r_b;
    w_acc    = i_start ? '0 : r_acc;
    w_sum    = w_acc;
    if (w_b[0]) begin
      w_sum = w_acc + w_a;
    end
  end

  assign o_done   = w_active && (w_cnt == CNT_W'(MUL_ITER - 1));
  assign o_result = w_sum;

  // Advance one bit per cycle; shift multiplicand up and multiplier down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (w_active) begin
      r_busy <= !o_done;
      r_cnt  <= w_cnt + CNT_W'(1);
      r_a    <= {w_a[DW-2:0], 1'b0};
      r_b    <= {1'b0, w_b[DW-1:1]};
      r_acc  <= w_sum;
    end
  end

endmodule

// File: rtl/alu_exec_wb.sv
// alu_exec_wb: execute/write-back stage in front of a 16x16 register file.
// Issue (k) -> EX (k+1) -> WB (k+2); MUL occupies EX for 16 cycles.
// Optional macro ALU_FWD_EN: forward the WB result into EX operands;
// without it, an issue that reads the EX destination is stalled one cycle.
module alu_exec_wb
  import alu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [DW-1:0] in_imm,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] rd_addr2,
  input  logic [DW-1:0] rd_data1,
  input  logic [DW-1:0] rd_data2,
  output logic          en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic [31:0]   retired,
  output logic [1:0]    o_dbg_state
);

  // Handshake: an instruction transfers on a rising edge where
  // in_valid && in_ready. While in_ready is low the issuer holds the
  // instruction and nothing is sampled.

  ex_state_e     r_state;
  ex_state_e     w_next_state;
  alu_op_e       w_in_op;
  alu_op_e       r_ex_op;
  logic [AW-1:0] r_ex_rd;
  logic [DW-1:0] r_ex_imm;
  logic          r_ex_first;
  logic          r_wb_valid;
  logic [AW-1:0] r_wb_rd;
  logic [DW-1:0] r_wb_data;
  logic [31:0]   r_retired;

  logic          w_accept;
  logic          w_hazard;
  logic          w_ready;
  logic          w_busy;
  logic          w_mul_start;
  logic          w_mul_done;
  logic          w_wb_load;
  logic [DW-1:0] w_opa;
  logic [DW-1:0] w_opb;
  logic [DW-1:0] w_alu_res;
  logic [DW-1:0] w_mul_res;

  assign w_in_op  = alu_op_e'(in_op);
  assign rd_addr1 = in_rs1;
  assign rd_addr2 = in_rs2;
  assign w_accept = in_valid && w_ready;

`ifdef ALU_FWD_EN
  logic [AW-1:0] r_ex_rs1;
  logic [AW-1:0] r_ex_rs2;

  assign w_hazard = 1'b0;

  // Remember EX source registers for the forwarding compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rs1 <= '0;
      r_ex_rs2 <= '0;
    end else if (w_accept) begin
      r_ex_rs1 <= in_rs1;
      r_ex_rs2 <= in_rs2;
    end
  end

  // Operand select: the WB result is newer than what the file returned.
  always_comb begin
    w_opa = rd_data1;
    w_opb = rd_data2;
    if (r_wb_valid && (r_wb_rd == r_ex_rs1)) begin
      w_opa = r_wb_data;
    end
    if (r_wb_valid && (r_wb_rd == r_ex_rs2)) begin
      w_opb = r_wb_data;
    end
  end
`else
  // Reading the EX destination: hold one cycle so write-through supplies it.
  assign w_hazard = (r_state == EX_ALU) &&
                    ((in_rs1 == r_ex_rd) || (in_rs2 == r_ex_rd));
  assign w_opa    = rd_data1;
  assign w_opb    = rd_data2;
`endif

  // EX state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EX_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // EX next state: MUL holds until its last iteration, otherwise follow accept.
  always_comb begin
    w_next_state = EX_IDLE;
    if ((r_state == EX_MUL) && !w_mul_done) begin
      w_next_state = EX_MUL;
    end else if (w_accept) begin
      w_next_state = is_mul(w_in_op) ? EX_MUL : EX_ALU;
    end
  end

  // FSM outputs: readiness, occupancy and multiplier kick-off.
  always_comb begin
    w_ready     = (r_state != EX_MUL) && !w_hazard;
    w_busy      = (r_state != EX_IDLE) || r_wb_valid;
    w_mul_start = (r_state == EX_MUL) && r_ex_first;
  end

  // Capture the accepted instruction into EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_op    <= OP_ADD;
      r_ex_rd    <= '0;
      r_ex_imm   <= '0;
      r_ex_first <= 1'b0;
    end else begin
      r_ex_first <= w_accept;
      if (w_accept) begin
        r_ex_op  <= w_in_op;
        r_ex_rd  <= in_rd;
        r_ex_imm <= in_imm;
      end
    end
  end

  // Single-cycle ALU result for the EX instruction.
  always_comb begin
    w_alu_res = '0;
    case (r_ex_op)
      OP_ADD:  w_alu_res = w_opa + w_opb;
      OP_SUB:  w_alu_res = w_opa - w_opb;
      OP_AND:  w_alu_res = w_opa & w_opb;
      OP_OR:   w_alu_res = w_opa | w_opb;
      OP_XOR:  w_alu_res = w_opa ^ w_opb;
      OP_SHL:  w_alu_res = w_opa << w_opb[3:0];
      OP_LDI:  w_alu_res = r_ex_imm;
      default: w_alu_res = '0;
    endcase
  end

  alu_mul_seq #(.DW(DW)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_a      (w_opa),
    .i_b      (w_opb),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  assign w_wb_load = (r_state == EX_ALU) || ((r_state == EX_MUL) && w_mul_done);

  // WB register: one-cycle write pulse; address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_wb_load;
      if (w_wb_load) begin
        r_wb_rd   <= r_ex_rd;
        r_wb_data <= (r_state == EX_MUL) ? w_mul_res : w_alu_res;
      end
    end
  end

  // Retired counter, wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (r_wb_valid) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign in_ready    = w_ready;
  assign busy        = w_busy;
  assign en          = r_wb_valid;
  assign wr_addr     = r_wb_rd;
  assign wr_data     = r_wb_data;
  assign retired     = r_retired;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_exec_wb.sv
// tb_alu_exec_wb: bench for alu_exec_wb with a register-file model,
// an architectural reference model and a write-back scoreboard.
`timescale 1ns/1ps
module tb_alu_exec_wb;
  localparam int DW = 16;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic rf_init;
  always #5 clk = ~clk;

  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic [AW-1:0] rd_addr1, rd_addr2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic [31:0]   retired;
  logic [1:0]    dbg_state;

  alu_exec_wb dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .en(en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .retired(retired), .o_dbg_state(dbg_state)
  );

  // register file: synchronous read with write-through
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      if (en) mem[wr_addr] <= wr_data;
      rd_data1 <= (en && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
      rd_data2 <= (en && wr_addr == rd_addr2) ? wr_data : mem[rd_addr2];
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // model / scoreboard state
  logic [DW-1:0]    arch [16];
  logic [AW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int last_acc_cycle = -1;
  int en_cycle_by_rd [16];
  logic [DW-1:0] en_data_by_rd [16];
  int n_writes = 0;
  int accepts_since_rst = 0;
  bit fwd_en;

  function automatic logic [DW-1:0] ref_result(input logic [2:0] op,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] imm);
    logic [31:0] full;
    case (op)
      3'd0: full = 32'(a) + 32'(b);
      3'd1: full = 32'(a) + 32'h10000 - 32'(b);
      3'd2: full = 32'(a & b);
      3'd3: full = 32'(a | b);
      3'd4: full = 32'(a ^ b);
      3'd5: full = 32'(a) * (32'd1 << (32'(b) % 32'd16));
      3'd6: full = 32'(imm);
      default: full = 32'(a) * 32'(b);
    endcase
    return full[DW-1:0];
  endfunction

  // per-cycle monitor, called on the falling edge
  task automatic monitor_step();
    logic [AW+DW-1:0] e;
    logic [DW-1:0] r;
    if (rst) begin
      for (int i = 0; i < 16; i++) arch[i] = mem[i];
      exp_q.delete();
      accepts_since_rst = 0;
    end else begin
      if (en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_fail++;
            $display("FAIL wb_value: got addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
        en_cycle_by_rd[wr_addr] = cycle;
        en_data_by_rd[wr_addr] = wr_data;
        n_writes++;
      end
      if (in_valid && in_ready) begin
        r = ref_result(in_op, arch[in_rs1], arch[in_rs2], in_imm);
        exp_q.push_back({in_rd, r});
        arch[in_rd] = r;
        last_acc_cycle = cycle;
        accepts_since_rst++;
      end
    end
  endtask

  // driver: present an instruction and hold it until accepted
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm);
    bit rdy;
    bit acc_ok;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    acc_ok = 1'b0;
    for (int i = 0; i < 40 && !acc_ok; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) acc_ok = 1'b1;
    end
    in_valid = 1'b0;
    if (!acc_ok) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: got no accept in 40 cycles, required accept (op=%0d)", op);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got busy=%b pending=%0d, required busy=0 pending=0", busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({en, wr_addr, wr_data, busy, in_ready} !== {1'b0, 4'h0, 16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b ready=%b, required 0/0/0000/0/1",
               en, wr_addr, wr_data, busy, in_ready);
    end
    n_checks++;
    if (retired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_retired: got %0d, required 0", retired);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ldi_add();
    int k;
    issue(3'd6, 4'd1, 4'd0, 4'd0, 16'h0003);
    k = last_acc_cycle;
    issue(3'd6, 4'd2, 4'd0, 4'd0, 16'h0005);
    issue(3'd0, 4'd3, 4'd1, 4'd2, 16'h0000);
    drain();
    n_checks++;
    if (en_cycle_by_rd[3] != k + (fwd_en ? 4 : 5) || en_data_by_rd[3] !== 16'h0008) begin
      n_fail++;
      $display("FAIL ldi_add: got cycle=%0d data=%h, required cycle=%0d data=0008",
               en_cycle_by_rd[3] - k, en_data_by_rd[3], fwd_en ? 4 : 5);
    end
    n_checks++;
    if (retired !== 32'd3) begin
      n_fail++;
      $display("FAIL ldi_add_retired: got %0d, required 3", retired);
    end
  endtask

  task automatic test_dep_sub();
    int a, b;
    issue(3'd6, 4'd3, 4'd0, 4'd0, 16'h0000);
    a = last_acc_cycle;
    issue(3'd1, 4'd4, 4'd3, 4'd1, 16'h0000);
    b = last_acc_cycle;
    drain();
    n_checks++;
    if (b - a != (fwd_en ? 1 : 2)) begin
      n_fail++;
      $display("FAIL dep_stall: got gap=%0d, required gap=%0d", b - a, fwd_en ? 1 : 2);
    end
    n_checks++;
    if (en_data_by_rd[4] !== 16'hFFFD || en_cycle_by_rd[4] != b + 2) begin
      n_fail++;
      $display("FAIL dep_sub: got data=%h lat=%0d, required data=FFFD lat=2",
               en_data_by_rd[4], en_cycle_by_rd[4] - b);
    end
  endtask

  task automatic test_mul_hold();
    int k, bad;
    issue(3'd6, 4'd1, 4'd0, 4'd0, 16'h0100);
    issue(3'd6, 4'd2, 4'd0, 4'd0, 16'h0101);
    drain();
    issue(3'd7, 4'd5, 4'd1, 4'd2, 16'h0000);
    k = last_acc_cycle;
    in_valid = 1'b1; in_op = 3'd0; in_rd = 4'd6; in_rs1 = 4'd1; in_rs2 = 4'd2; in_imm = '0;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mul_ready_low: got %0d cycles ready in k+1..k+16, required 0", bad);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_ready_back: got in_ready=%b at k+17, required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
    n_checks++;
    if (last_acc_cycle != k + 17) begin
      n_fail++;
      $display("FAIL held_add_accept: got k+%0d, required k+17", last_acc_cycle - k);
    end
    n_checks++;
    if (en_cycle_by_rd[5] != k + 17 || en_data_by_rd[5] !== 16'h0100) begin
      n_fail++;
      $display("FAIL mul_result: got lat=%0d data=%h, required lat=17 data=0100",
               en_cycle_by_rd[5] - k, en_data_by_rd[5]);
    end
    n_checks++;
    if (en_cycle_by_rd[6] != k + 19 || en_data_by_rd[6] !== 16'h0201) begin
      n_fail++;
      $display("FAIL held_add_wb: got lat=%0d data=%h, required lat=19 data=0201",
               en_cycle_by_rd[6] - k, en_data_by_rd[6]);
    end
  endtask

  task automatic test_shl_xor();
    issue(3'd6, 4'd6, 4'd0, 4'd0, 16'h0001);
    issue(3'd6, 4'd7, 4'd0, 4'd0, 16'h0013);
    issue(3'd5, 4'd8, 4'd6, 4'd7, 16'h0000);
    issue(3'd4, 4'd9, 4'd8, 4'd8, 16'h0000);
    drain();
    n_checks++;
    if (en_data_by_rd[8] !== 16'h0008) begin
      n_fail++;
      $display("FAIL shl: got %h, required 0008", en_data_by_rd[8]);
    end
    n_checks++;
    if (en_data_by_rd[9] !== 16'h0000) begin
      n_fail++;
      $display("FAIL xor_self: got %h, required 0000", en_data_by_rd[9]);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    issue(3'd0, 4'd11, 4'd1, 4'd2, 16'h0000);
    k = last_acc_cycle;
    issue(3'd1, 4'd12, 4'd1, 4'd2, 16'h0000);
    issue(3'd3, 4'd13, 4'd1, 4'd2, 16'h0000);
    issue(3'd2, 4'd14, 4'd1, 4'd2, 16'h0000);
    n_checks++;
    if (last_acc_cycle != k + 3) begin
      n_fail++;
      $display("FAIL throughput: got 4 accepts over %0d cycles, required 4", last_acc_cycle - k + 1);
    end
    drain();
  endtask

  task automatic test_reset_mid_mul();
    int w0;
    issue(3'd7, 4'd10, 4'd1, 4'd2, 16'h0000);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({en, wr_addr, wr_data, busy, in_ready} !== {1'b0, 4'h0, 16'h0000, 1'b0, 1'b1} ||
        retired !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_mul_reset: got en=%b addr=%0d data=%h busy=%b ready=%b ret=%0d, required reset values",
               en, wr_addr, wr_data, busy, in_ready, retired);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    w0 = n_writes;
    repeat (25) @(posedge clk);
    #1;
    n_checks++;
    if (n_writes != w0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_abandoned: got writes=%0d ready=%b, required writes=0 ready=1",
               n_writes - w0, in_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) begin
          @(posedge clk); #1;
        end
      end
    end
    drain();
    n_checks++;
    if (retired !== 32'(accepts_since_rst)) begin
      n_fail++;
      $display("FAIL random_retired: got %0d, required %0d", retired, accepts_since_rst);
    end
  endtask

  initial begin
`ifdef ALU_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      en_cycle_by_rd[i] = -1;
      en_data_by_rd[i] = '0;
    end
    rst = 1'b1; rf_init = 1'b1;
    in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    rf_init = 1'b0;
    rst = 1'b0;
    test_reset();
    test_ldi_add();
    test_dep_sub();
    test_mul_hold();
    test_shl_xor();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish by 2ms, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_exec_wb.md
# alu_exec_wb

Execute/write-back stage sitting directly in front of the 16x16 register file `reg_rtl`. Accepts one register-register instruction per cycle via a valid/ready handshake. Drives the register file's read addresses, consumes `rd_data1`/`rd_data2` one cycle later, and computes the result. Writes the result back through the file's `en`/`wr_addr`/`wr_data` port. Single-cycle ALU ops are pipelined; MUL is a multi-cycle iterative operation that back-pressures the issuer.

## Interface
- `DW`, 16, data width; must match register file width
- `AW`, 4, register address width (16 registers)
- `clk` in 1 rising-edge clock
- `rst` in 1 asynchronous, active-high reset
- `in_valid` in 1 instruction present
- `in_ready` out 1 stage can accept; transfer when `in_valid && in_ready` at a rising edge
- `in_op` in 3 opcode
- `in_rd`, `in_rs1`, `in_rs2` in AW each destination and source registers
- `in_imm` in DW immediate for LDI
- `rd_addr1`, `rd_addr2` out AW each to register file; combinational copies of `in_rs1`/`in_rs2`
- `rd_data1`, `rd_data2` in DW each from register file; valid the cycle after the address was presented
- `en` out 1 register-file write enable
- `wr_addr` out AW write address
- `wr_data` out DW write data
- `busy` out 1 an instruction is in EX or WB
- `retired` out 32 count of write-backs, wraps at 2^32

## Operation
- Opcodes (all results mod 2^DW, no flags):
  - 000 ADD: rs1+rs2
  - 001 SUB: rs1-rs2
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: rs1 << rs2[3:0]
  - 110 LDI: imm, sources ignored for the result
  - 111 MUL: low DW bits of rs1*rs2
- Pipeline:
  - ISSUE (cycle k): accept; register file samples `rd_addr*` at the end of k.
  - EX (k+1): operands are `rd_data*`, or forwarded values; result registered.
  - WB (k+2): `en`=1 for exactly one cycle with `wr_addr`/`wr_data`.
- Forwarding: if the EX instruction's rs1/rs2 equals the WB instruction's rd, the operand is taken from `wr_data`, not `rd_data`. An instruction two slots back is covered by the register file's own write-through.
- EX state machine:
  - EX_IDLE: go to EX_ALU on accept of a non-MUL op, or EX_MUL on accept of MUL.
  - EX_ALU: lasts one cycle, then goes to EX_ALU, EX_MUL or EX_IDLE per the next accept.
  - EX_MUL: shift-add, one multiplier bit per cycle, 16 cycles, counter 0..15. On count 15, the result is registered and the state leaves as for EX_ALU.
- `in_ready` is 0 while in EX_MUL, including the final iteration; otherwise 1.
- Writing register 0 is an ordinary write; no hardwired zero.
- `retired` increments on every cycle with `en`=1.

## Timing
- Reset values: `en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `retired`=0, state EX_IDLE, `in_ready`=1.
- Reset mid-MUL or with a WB pending: operation abandoned, no write issued after reset release.
- ALU latency: accept at k gives `en` at k+2. Throughput is 1/cycle.
- MUL latency: accept at k, EX cycles k+1..k+16, `en` at k+17. `in_ready` is 0 in k+1..k+16, so the next accept is at k+17 at the earliest.
- Back-to-back dependent ops, e.g. ADD r1 then ADD r2,r1,r1 at k and k+1: the second reads the forwarded value at k+2.
- `in_valid` high while `in_ready` is low: instruction held by the issuer; nothing sampled.
- `rd_addr*` follow `in_rs*` every cycle regardless of the handshake; reads without an accept are discarded.

## Configuration
- `ALU_FWD_EN` defined: forwarding as above. `in_ready` is only ever dropped by MUL.
- Undefined: no forwarding mux. On an accepted op whose rs1 or rs2 equals the rd of the instruction in EX (compared for all ops, LDI included), stall instead:
  - `in_ready`=0 for one cycle.
  - The held instruction is accepted the next cycle and relies on register-file write-through.
  - Latency for that instruction increases by one cycle; results are identical.

## Structure
- Shared package `alu_pkg`:
  - opcode enum `alu_op_e`
  - `DW`/`AW` defaults
  - `MUL_ITER`=16
- Sub-module `alu_mul_seq`:
  - iterative shift-add multiplier
  - start/done handshake and internal 4-bit counter

## Test plan
- LDI r1,0x0003 then LDI r2,0x0005 then ADD r3,r1,r2, issued back-to-back → `en` at k+4 with `wr_addr`=3, `wr_data`=0x0008; `retired`=3.
- SUB r4,r3,r1 immediately after an LDI r3,0x0000 (dependent, back-to-back) → `wr_data`=0xFFFD. Run with and without `ALU_FWD_EN`; the stall cycle is seen only without it.
- MUL r5,r1,r2 with 0x0100 * 0x0101 → `wr_data`=0x0100 (low 16 bits) at k+17. `in_ready`=0 for cycles k+1..k+16.
- SHL with rs2=0x0013 on 0x0001 → shift by 3, result 0x0008. XOR of a register with itself → 0x0000.
- Assert `rst` at cycle 8 of a MUL → `en` never pulses for that MUL; all outputs at reset values; `in_ready`=1 after release.
- Hold `in_valid`=1 during MUL with a new ADD → ADD accepted exactly at k+17 and written at k+19.
